pc_wb_unit: RTL
===============

// Module: pc_wb_unit
// PURPOSE
//  Registered successor to the combinational PC/writeback selection logic.
//  Owns the program counter register and computes next PC for the sequential,
//  branch (14b/24b offset) and register-indirect modes, all parametrised in width.
//  Registers the register-file writeback value and waits for load data through
//  a valid handshake; the PC is held until the wait completes.
//  Sits between decode/ALU/data-memory and the register file in the core.
// PARAMETERS
//  DataSize  32  datapath width (register file / ALU / memory data)
//  PcSize    10  program counter width; all PC arithmetic is modulo 2^PcSize
//  ResetPc   0   PC value loaded on reset
//  PcStep    4   sequential PC increment
// PORTS
//  clk              in   1          clock; all state updates on rising edge
//  rst              in   1          synchronous reset, active-high
//  stall            in   1          1 = hold PC this cycle
//  select_pc        in   2          00 +PcStep, 01 imm_14bit branch, 10 imm_24bit branch, 11 register-indirect
//  imm_14bit        in   14         signed branch offset (halfword units)
//  imm_24bit        in   24         signed jump offset (halfword units)
//  jump_reg_data    in   DataSize   register-indirect target
//  current_pc       out  PcSize     registered PC
//  next_pc          out  PcSize     combinational PC candidate
//  wb_request       in   1          1 = writeback to be performed this cycle
//  write_reg_select in   2          00 alu_output, 01 imm_reg_data, 10 mem_read_data, 11 illegal
//  wb_addr          in   5          destination register index
//  alu_output       in   DataSize   ALU result
//  imm_reg_data     in   DataSize   immediate / operand-mux value
//  mem_read_data    in   DataSize   load data
//  mem_read_valid   in   1          1 = mem_read_data valid this cycle
//  write_reg_data   out  DataSize   registered writeback data
//  write_reg_addr   out  5          registered writeback index
//  write_reg_valid  out  1          one-cycle write-enable pulse to the register file
//  wb_busy          out  1          1 = state WAIT_MEM (waiting for load data)
//  wb_error         out  1          one-cycle pulse on an illegal select
// BEHAVIOUR
//  Reset: current_pc=ResetPc; write_reg_data=0; write_reg_addr=0; write_reg_valid=0;
//   wb_error=0; state=IDLE (wb_busy=0). Reset mid-WAIT_MEM drops the pending load,
//   and no valid pulse is issued.
//  next_pc (combinational, computed from current_pc):
//   00: current_pc+PcStep
//   01: current_pc+(sext(imm_14bit)<<1)
//   10: current_pc+(sext(imm_24bit)<<1)
//   11: jump_reg_data[PcSize-1:0]
//   Results are truncated to PcSize bits, so wrap-around is silent.
//  PC update: current_pc<=next_pc on each edge unless stall=1 or state==WAIT_MEM.
//   Both conditions together also hold the PC. The PC still advances in the cycle
//   a request enters WAIT_MEM.
//  Writeback FSM {IDLE, WAIT_MEM}:
//   Latency is 1 cycle: the outputs are registered.
//   IDLE, wb_request=0: write_reg_valid=0, and the data/addr registers hold.
//   IDLE, wb_request=1, sel 00/01: capture the source and wb_addr, then
//    write_reg_valid=1 next cycle.
//   IDLE, wb_request=1, sel 10, mem_read_valid=1: capture mem_read_data, then
//    write_reg_valid=1 next cycle.
//   IDLE, wb_request=1, sel 10, mem_read_valid=0: latch wb_addr, go to WAIT_MEM,
//    no valid pulse.
//   IDLE, wb_request=1, sel 11: no write (write_reg_valid=0), wb_error=1 for 1 cycle.
//   WAIT_MEM: wb_request and the selects are ignored. On mem_read_valid=1, capture
//    mem_read_data, pulse write_reg_valid with the latched addr, and return to IDLE.
//    There is no timeout.
//  write_reg_valid and wb_error are never high for two consecutive cycles from one
//   request. stall does not affect the writeback FSM.
// TESTING
//  1 rst=1 for 2 clk, release -> current_pc=0, write_reg_valid=0, wb_busy=0.
//  2 select_pc=00 for 3 clk from PC=0x3F8 -> 0x3FC, 0x000, 0x004 (wrap with PcSize=10).
//  3 PC=0x100, sel 01, imm_14bit=14'h3FFC -> PC=0x0F8; sel 11, jump_reg_data=0x12345 -> PC=0x345.
//  4 wb_request, sel 00, alu_output=0xDEADBEEF, wb_addr=7 -> next cycle data=0xDEADBEEF,
//    addr=7, valid=1 for exactly 1 cycle.
//  5 wb_request, sel 10, mem_read_valid=0, wb_addr=3; mem_read_valid=1 with data 0xA5A5 three
//    cycles later -> wb_busy=1 and PC held for 3 cycles; then data=0xA5A5, addr=3,
//    valid=1, wb_busy=0.
//  6 rst during WAIT_MEM -> no valid pulse, wb_busy=0, PC=ResetPc; sel 11 -> wb_error 1-cycle pulse, no write.

Source files
------------

// File: rtl/pc_wb_unit_if.sv
// rtl/pc_wb_unit_if.sv - PC control and writeback bus between core stages and pc_wb_unit
interface pc_wb_unit_if #(
  parameter int DataSize = 32,
  parameter int PcSize   = 10
);
  logic                stall;
  logic [1:0]          select_pc;
  logic [13:0]         imm_14bit;
  logic [23:0]         imm_24bit;
  logic [DataSize-1:0] jump_reg_data;
  logic [PcSize-1:0]   current_pc;
  logic [PcSize-1:0]   next_pc;

  logic                wb_request;
  logic [1:0]          write_reg_select;
  logic [4:0]          wb_addr;
  logic [DataSize-1:0] alu_output;
  logic [DataSize-1:0] imm_reg_data;
  logic [DataSize-1:0] mem_read_data;
  logic                mem_read_valid;
  logic [DataSize-1:0] write_reg_data;
  logic [4:0]          write_reg_addr;
  logic                write_reg_valid;
  logic                wb_busy;
  logic                wb_error;

  modport master (
    output stall, select_pc, imm_14bit, imm_24bit, jump_reg_data,
    output wb_request, write_reg_select, wb_addr, alu_output, imm_reg_data,
    output mem_read_data, mem_read_valid,
    input  current_pc, next_pc, write_reg_data, write_reg_addr,
    input  write_reg_valid, wb_busy, wb_error
  );

  modport slave (
    input  stall, select_pc, imm_14bit, imm_24bit, jump_reg_data,
    input  wb_request, write_reg_select, wb_addr, alu_output, imm_reg_data,
    input  mem_read_data, mem_read_valid,
    output current_pc, next_pc, write_reg_data, write_reg_addr,
    output write_reg_valid, wb_busy, wb_error
  );
endinterface

// File: rtl/pc_wb_unit.sv
// rtl/pc_wb_unit.sv - program counter register plus registered writeback with load-data wait
module pc_wb_unit #(
  parameter int DataSize = 32,
  parameter int PcSize   = 10,
  parameter int ResetPc  = 0,
  parameter int PcStep   = 4
) (
  input logic         clk,
  input logic         rst,
  pc_wb_unit_if.slave bus
);
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_MEM = 1'b1;

  // Wide enough to sign-extend either offset with at least one guard bit.
  localparam int ExtW = ((PcSize > 25) ? PcSize : 25) + 1;

  logic [PcSize-1:0]   pc_q, pc_d;
  logic [PcSize-1:0]   next_pc;
  logic [0:0]          state_q, state_d;
  logic [DataSize-1:0] data_q, data_d;
  logic [4:0]          addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;

  logic [ExtW-1:0]     off14, off24;
  logic                unused_bits;

  assign off14 = {{(ExtW-15){bus.imm_14bit[13]}}, bus.imm_14bit, 1'b0};
  assign off24 = {{(ExtW-25){bus.imm_24bit[23]}}, bus.imm_24bit, 1'b0};
  assign unused_bits = ^{off14[ExtW-1:PcSize], off24[ExtW-1:PcSize],
                         bus.jump_reg_data[DataSize-1:PcSize]};

  always_comb begin
    next_pc = pc_q + PcSize'(PcStep);
    case (bus.select_pc)
      2'b00:   next_pc = pc_q + PcSize'(PcStep);
      2'b01:   next_pc = pc_q + off14[PcSize-1:0];
      2'b10:   next_pc = pc_q + off24[PcSize-1:0];
      default: next_pc = bus.jump_reg_data[PcSize-1:0];
    endcase
  end

  // The PC freezes for the whole load wait but still advances on the entry cycle.
  always_comb begin
    pc_d = pc_q;
    if (!bus.stall && state_q == ST_IDLE) pc_d = next_pc;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (state_q == ST_WAIT_MEM) begin
      if (bus.mem_read_valid) begin
        data_d  = bus.mem_read_data;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (bus.wb_request) begin
      case (bus.write_reg_select)
        2'b00: begin
          data_d  = bus.alu_output;
          addr_d  = bus.wb_addr;
          valid_d = 1'b1;
        end
        2'b01: begin
          data_d  = bus.imm_reg_data;
          addr_d  = bus.wb_addr;
          valid_d = 1'b1;
        end
        2'b10: begin
          addr_d = bus.wb_addr;
          if (bus.mem_read_valid) begin
            data_d  = bus.mem_read_data;
            valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT_MEM;
          end
        end
        default: error_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PcSize'(ResetPc);
      state_q <= ST_IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign bus.current_pc      = pc_q;
  assign bus.next_pc         = next_pc;
  assign bus.write_reg_data  = data_q;
  assign bus.write_reg_addr  = addr_q;
  assign bus.write_reg_valid = valid_q;
  assign bus.wb_busy         = (state_q == ST_WAIT_MEM);
  assign bus.wb_error        = error_q;
endmodule
